// File: rtl/pipelined_addsub_pkg.sv
// Shared helpers for the segmented, carry-pipelined adder/subtractor.
package pipelined_addsub_pkg;

  function automatic int seg_w(input int n, input int stages);
    return n / stages;
  endfunction

  function automatic bit seg_ok(input int n, input int stages);
    return (stages > 0) && (stages <= n) && ((n % stages) == 0);
  endfunction

endpackage

// File: rtl/addsub_seg.sv
// Combinational W-bit ripple segment built from per-bit full adders.
module addsub_seg #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  // Each bit owns its carry so the chain stays a plain netlist
  for (genvar i = 0; i < W; i++) begin : g_bit
    logic ci;
    logic co;
    if (i == 0) begin : g_lsb
      assign ci = cin;
    end else begin : g_up
      assign ci = g_bit[i-1].co;
    end
    assign sum[i] = a[i] ^ b[i] ^ ci;
    assign co = (a[i] & b[i]) | (ci & (a[i] ^ b[i]));
  end

  assign cout = g_bit[W-1].co;

endmodule

// File: rtl/pipelined_addsub.sv
// N-bit adder/subtractor, one W-bit ripple segment per stage,
// registered inter-segment carry and a global valid/ready stall.
module pipelined_addsub
  import pipelined_addsub_pkg::*;
#(
  parameter int N      = 32,
  parameter int STAGES = 4,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic             cin,
  input  logic             sub,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     sum,
  output logic             cout,
  output logic             ovf,
  output logic [TAG_W-1:0] tag_out
);

  localparam int W = seg_w(N, STAGES);

  if (!seg_ok(N, STAGES)) begin : g_chk
    $error("pipelined_addsub: N must be a multiple of STAGES");
  end

  logic              advance;
  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES-1:0] c_q, c_d;
  logic [STAGES-1:0] ci;
  logic              ovf_q, ovf_d;

  logic [N-1:0]      a_q   [STAGES];
  logic [N-1:0]      a_d   [STAGES];
  logic [N-1:0]      b_q   [STAGES];
  logic [N-1:0]      b_d   [STAGES];
  logic [N-1:0]      s_q   [STAGES];
  logic [N-1:0]      s_d   [STAGES];
  logic [TAG_W-1:0]  t_q   [STAGES];
  logic [TAG_W-1:0]  t_d   [STAGES];
  logic              sub_q [STAGES];
  logic              sub_d [STAGES];
  logic              bm_q  [STAGES];
  logic              bm_d  [STAGES];
  logic [W-1:0]      seg_s [STAGES];

  assign advance  = !(v_q[STAGES-1] && !out_ready);
  assign in_ready = advance;

  // Stage inputs: operand prep at acceptance, then skewed hand-off
  always_comb begin
    a_d[0]   = a;
    b_d[0]   = sub ? ~b : b;
    ci[0]    = cin ^ sub;
    v_d[0]   = in_valid;
    t_d[0]   = tag_in;
    sub_d[0] = sub;
    bm_d[0]  = b[N-1];
    for (int k = 1; k < STAGES; k++) begin
      a_d[k]   = a_q[k-1];
      b_d[k]   = b_q[k-1];
      ci[k]    = c_q[k-1];
      v_d[k]   = v_q[k-1];
      t_d[k]   = t_q[k-1];
      sub_d[k] = sub_q[k-1];
      bm_d[k]  = bm_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    addsub_seg #(
      .W(W)
    ) u_seg (
      .a   (a_d[k][k*W +: W]),
      .b   (b_d[k][k*W +: W]),
      .cin (ci[k]),
      .sum (seg_s[k]),
      .cout(c_d[k])
    );
  end

  // Finished low segments ride forward so the word exits aligned
  always_comb begin
    s_d[0] = '0;
    s_d[0][W-1:0] = seg_s[0];
    for (int k = 1; k < STAGES; k++) begin
      s_d[k] = s_q[k-1];
      s_d[k][k*W +: W] = seg_s[k];
    end
    ovf_d = (a_d[STAGES-1][N-1] ==
             (bm_d[STAGES-1] ^ sub_d[STAGES-1]))
         && (seg_s[STAGES-1][W-1] != a_d[STAGES-1][N-1]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        s_q[k]   <= '0;
        t_q[k]   <= '0;
        sub_q[k] <= 1'b0;
        bm_q[k]  <= 1'b0;
      end
    end else if (advance) begin
      v_q   <= v_d;
      c_q   <= c_d;
      ovf_q <= ovf_d;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        s_q[k]   <= s_d[k];
        t_q[k]   <= t_d[k];
        sub_q[k] <= sub_d[k];
        bm_q[k]  <= bm_d[k];
      end
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = ovf_q;
  assign tag_out   = t_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench: three depths (4, 1, 32) share stimulus; each has its own
// queue-based reference model and a per-cycle output compare.
module tb_pipelined_addsub;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_ready = 1'b1;
  logic        end_chk = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [3:0]  tag_in = '0;
  logic [2:0]  rdy_w;
  logic [2:0]  ov_w;
  logic [31:0] sum0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic [3:0]  tag;
    int          acc;
    int          st;
  } exp_t;

  // Reference: plain wide arithmetic, signed range test for ovf
  function automatic logic [33:0] ref_op(
    input logic [31:0] fa,
    input logic [31:0] fb,
    input logic        fc,
    input logic        fs
  );
    logic [31:0] be;
    logic        c0;
    logic [32:0] r;
    longint      t;
    logic        o;
    be = fs ? ~fb : fb;
    c0 = fc ^ fs;
    r  = {1'b0, fa} + {1'b0, be} + {32'd0, c0};
    t  = longint'($signed(fa)) + longint'($signed(be))
       + longint'({63'd0, c0});
    o  = (t > 64'sd2147483647) || (t < -64'sd2147483648);
    return {o, r[32], r[31:0]};
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
    localparam int ST = (gi == 0) ? 4 : ((gi == 1) ? 1 : 32);
    logic        irdy, ov, co, of;
    logic [31:0] sm;
    logic [3:0]  tg;
    exp_t        q[$];
    exp_t        e;
    int          lc = 0;
    int          stalls = 0;
    bit          shown = 1'b0;
    logic        rst_prev = 1'b0;
    logic [33:0] r;

    pipelined_addsub #(
      .N(32), .STAGES(ST), .TAG_W(4)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (irdy),
      .a        (a),
      .b        (b),
      .cin      (cin),
      .sub      (sub),
      .tag_in   (tag_in),
      .out_valid(ov),
      .out_ready(out_ready),
      .sum      (sm),
      .cout     (co),
      .ovf      (of),
      .tag_out  (tg)
    );

    assign rdy_w[gi] = irdy;
    assign ov_w[gi]  = ov;
    if (gi == 0) begin : g_mon
      assign sum0 = sm;
    end

    always @(posedge clk) begin
      lc++;
      rst_prev = rst_n;
      if (!rst_n) begin
        q.delete();
        shown = 1'b0;
      end else begin
        if (ov && !out_ready) stalls++;
        if (ov && out_ready && q.size() > 0) begin
          void'(q.pop_front());
          shown = 1'b0;
        end
        if (in_valid && irdy) begin
          r = ref_op(a, b, cin, sub);
          e.sum  = r[31:0];
          e.cout = r[32];
          e.ovf  = r[33];
          e.tag  = tag_in;
          e.acc  = lc;
          e.st   = stalls;
          q.push_back(e);
        end
      end
    end

    always @(negedge clk) begin
      if (!rst_prev) begin
        checks++;
        if (ov !== 1'b0 || sm !== 32'd0 || co !== 1'b0
            || of !== 1'b0 || tg !== 4'd0) begin
          failures++;
          $display("FAIL rst_clear st=%0d valid=%b sum=%h cout=%b ovf=%b tag=%h required all zero",
                   ST, ov, sm, co, of, tg);
        end
      end else begin
        checks++;
        if (irdy !== !(ov && !out_ready)) begin
          failures++;
          $display("FAIL in_ready st=%0d got=%b required=%b",
                   ST, irdy, !(ov && !out_ready));
        end
        if (ov === 1'b1) begin
          checks++;
          if (q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_out st=%0d sum=%h tag=%h required no output",
                     ST, sm, tg);
          end else begin
            if ({sm, co, of, tg} !==
                {q[0].sum, q[0].cout, q[0].ovf, q[0].tag}) begin
              failures++;
              $display("FAIL result st=%0d got sum=%h cout=%b ovf=%b tag=%h required sum=%h cout=%b ovf=%b tag=%h",
                       ST, sm, co, of, tg,
                       q[0].sum, q[0].cout, q[0].ovf, q[0].tag);
            end
            if (!shown) begin
              checks++;
              if (lc != q[0].acc + ST - 1 + (stalls - q[0].st)) begin
                failures++;
                $display("FAIL latency st=%0d got cycle=%0d required=%0d",
                         ST, lc,
                         q[0].acc + ST - 1 + (stalls - q[0].st));
              end
              shown = 1'b1;
            end
          end
        end
      end
      if (end_chk) begin
        checks++;
        if (q.size() != 0 || ov !== 1'b0) begin
          failures++;
          $display("FAIL drain st=%0d pending=%0d valid=%b required 0 and 0",
                   ST, q.size(), ov);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(
    input logic [31:0] ia,
    input logic [31:0] ib,
    input logic        ic,
    input logic        is,
    input logic [3:0]  it
  );
    bit acc;
    a = ia;
    b = ib;
    cin = ic;
    sub = is;
    tag_in = it;
    in_valid = 1'b1;
    acc = 1'b0;
    for (int n = 0; n < 100 && !acc; n++) begin
      @(negedge clk);
      acc = rdy_w[0];
      @(posedge clk);
      #1;
    end
    checks++;
    if (!acc) begin
      failures++;
      $display("FAIL send_timeout tag=%h accepted=0 required=1", it);
    end
    in_valid = 1'b0;
  endtask

  logic [31:0] da [5] = '{32'h0000_FFFF, 32'hFFFF_FFFF,
                          32'h7FFF_FFFF, 32'h0000_0005,
                          32'h8000_0000};
  logic [31:0] db [5] = '{32'h0000_0001, 32'h0000_0001,
                          32'h0000_0001, 32'h0000_0007,
                          32'h0000_0001};
  logic        ds [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [33:0] dx [5] = '{{2'b00, 32'h0001_0000},
                          {2'b01, 32'h0000_0000},
                          {2'b10, 32'h8000_0000},
                          {2'b00, 32'hFFFF_FFFE},
                          {2'b11, 32'h7FFF_FFFF}};

  logic [31:0] ra [16];
  logic [31:0] rb [16];
  logic        rc [16];
  logic        rs [16];
  logic [33:0] pin;
  logic [31:0] hold;

  initial begin
    repeat (3) tick();
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      pin = ref_op(da[i], db[i], 1'b0, ds[i]);
      checks++;
      if (pin !== dx[i]) begin
        failures++;
        $display("FAIL model_pin case=%0d got=%h required=%h",
                 i, pin, dx[i]);
      end
    end

    for (int i = 0; i < 5; i++)
      send(da[i], db[i], 1'b0, ds[i], 4'(i + 1));
    repeat (40) tick();

    for (int i = 0; i < 16; i++) begin
      ra[i] = $urandom;
      rb[i] = $urandom;
      rc[i] = 1'($urandom_range(0, 1));
      rs[i] = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < 16; i++) begin
      if (i == 6) begin
        a = ra[i];
        b = rb[i];
        cin = rc[i];
        sub = rs[i];
        tag_in = 4'(i);
        in_valid = 1'b1;
        out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          checks++;
          if (rdy_w[0] !== 1'b0 || ov_w[0] !== 1'b1) begin
            failures++;
            $display("FAIL stall_ready in_ready=%b valid=%b required 0 and 1",
                     rdy_w[0], ov_w[0]);
          end
          if (j == 0) begin
            hold = sum0;
          end else begin
            checks++;
            if (sum0 !== hold) begin
              failures++;
              $display("FAIL stall_hold got=%h required=%h",
                       sum0, hold);
            end
          end
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
      send(ra[i], rb[i], rc[i], rs[i], 4'(i));
    end

    for (int i = 0; i < 80; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      a         = $urandom;
      b         = $urandom;
      cin       = 1'($urandom_range(0, 1));
      sub       = 1'($urandom_range(0, 1));
      tag_in    = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (40) tick();

    send(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 4'hA);
    send(32'h3333_3333, 32'h0000_0001, 1'b1, 1'b1, 4'hB);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 4'hC);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (45) tick();

    end_chk = 1'b1;
    tick();
    end_chk = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
